// File: rtl/axi_r_resp_arbiter_if.sv
// rtl/axi_r_resp_arbiter_if.sv - R-channel bundle between slave-side channels and the master port
interface axi_r_resp_arbiter_if #(
  parameter int NUM_SLV    = 4,
  parameter int ID_WIDTH   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 10
);
  logic [NUM_SLV-1:0]            slv_valid_i;
  logic [NUM_SLV*DATA_WIDTH-1:0] slv_data_i;
  logic [NUM_SLV*2-1:0]          slv_resp_i;
  logic [NUM_SLV*USER_WIDTH-1:0] slv_user_i;
  logic [NUM_SLV*ID_WIDTH-1:0]   slv_id_i;
  logic [NUM_SLV-1:0]            slv_last_i;
  logic [NUM_SLV-1:0]            slv_ready_o;
  logic                          mst_valid_o;
  logic [DATA_WIDTH-1:0]         mst_data_o;
  logic [1:0]                    mst_resp_o;
  logic [USER_WIDTH-1:0]         mst_user_o;
  logic [ID_WIDTH-1:0]           mst_id_o;
  logic                          mst_last_o;
  logic                          mst_ready_i;

  // slave: the arbiter's view; master: the surrounding fabric's view
  modport slave (
    input  slv_valid_i, slv_data_i, slv_resp_i, slv_user_i, slv_id_i, slv_last_i, mst_ready_i,
    output slv_ready_o, mst_valid_o, mst_data_o, mst_resp_o, mst_user_o, mst_id_o, mst_last_o
  );

  modport master (
    output slv_valid_i, slv_data_i, slv_resp_i, slv_user_i, slv_id_i, slv_last_i, mst_ready_i,
    input  slv_ready_o, mst_valid_o, mst_data_o, mst_resp_o, mst_user_o, mst_id_o, mst_last_o
  );
endinterface

// File: rtl/axi_r_resp_arbiter.sv
// rtl/axi_r_resp_arbiter.sv - round-robin per-burst merge of NUM_SLV AXI R channels, registered output
module axi_r_resp_arbiter #(
  parameter int NUM_SLV    = 4,
  parameter int IDX_W      = 2,
  parameter int ID_WIDTH   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  axi_r_resp_arbiter_if.slave  bus,
  output logic                 arb_locked_o,
  output logic [IDX_W-1:0]     arb_grant_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      sel;
  logic                  sel_found;
  logic                  can_load;
  logic                  accept;
  logic                  sel_last;
  logic [NUM_SLV-1:0]    slv_ready;

  logic                  mst_valid_q;
  logic [DATA_WIDTH-1:0] mst_data_q;
  logic [1:0]            mst_resp_q;
  logic [USER_WIDTH-1:0] mst_user_q;
  logic [ID_WIDTH-1:0]   mst_id_q;
  logic                  mst_last_q;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int t;
    t = int'(base) + k;
    if (t >= NUM_SLV) t = t - NUM_SLV;
    return IDX_W'(t);
  endfunction

  // Descending scan so the candidate closest to rr_ptr (smallest offset) wins.
  always_comb begin
    sel       = grant_q;
    sel_found = 1'b0;
    if (state_q == LOCKED) begin
      sel_found = 1'b1;
    end else begin
      for (int k = NUM_SLV - 1; k >= 0; k--) begin
        if (bus.slv_valid_i[wrap_add(rr_ptr_q, k)]) begin
          sel       = wrap_add(rr_ptr_q, k);
          sel_found = 1'b1;
        end
      end
    end
  end

  assign can_load = !mst_valid_q || bus.mst_ready_i;
  assign sel_last = bus.slv_last_i[sel];
  assign accept   = rst_ni && sel_found && bus.slv_valid_i[sel] && can_load;

  always_comb begin
    slv_ready = '0;
    if (rst_ni && sel_found) slv_ready[sel] = can_load;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      grant_d = sel;
      if (sel_last) begin
        state_d  = IDLE;
        rr_ptr_d = wrap_add(sel, 1);
      end else begin
        state_d = LOCKED;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      mst_valid_q <= 1'b0;
      mst_data_q  <= '0;
      mst_resp_q  <= '0;
      mst_user_q  <= '0;
      mst_id_q    <= '0;
      mst_last_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      if (accept) begin
        mst_valid_q <= 1'b1;
        mst_data_q  <= bus.slv_data_i[sel*DATA_WIDTH +: DATA_WIDTH];
        mst_resp_q  <= bus.slv_resp_i[sel*2 +: 2];
        mst_user_q  <= bus.slv_user_i[sel*USER_WIDTH +: USER_WIDTH];
        mst_id_q    <= bus.slv_id_i[sel*ID_WIDTH +: ID_WIDTH];
        mst_last_q  <= sel_last;
      end else if (bus.mst_ready_i) begin
        mst_valid_q <= 1'b0;
      end
    end
  end

  assign bus.slv_ready_o = slv_ready;
  assign bus.mst_valid_o = mst_valid_q;
  assign bus.mst_data_o  = mst_data_q;
  assign bus.mst_resp_o  = mst_resp_q;
  assign bus.mst_user_o  = mst_user_q;
  assign bus.mst_id_o    = mst_id_q;
  assign bus.mst_last_o  = mst_last_q;
  assign arb_locked_o    = (state_q == LOCKED);
  assign arb_grant_o     = grant_q;

endmodule

// File: tb/tb_axi_r_resp_arbiter.sv
// tb/tb_axi_r_resp_arbiter.sv - vector table plus randomized burst streams against a round-robin model
module tb_axi_r_resp_arbiter;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int IDW = 16;
  localparam int DW  = 32;
  localparam int UW  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          locked;
  logic [IW-1:0] grant;

  always #5 clk = ~clk;

  axi_r_resp_arbiter_if #(.NUM_SLV(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();

  axi_r_resp_arbiter #(.NUM_SLV(N), .IDX_W(IW), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .arb_locked_o(locked), .arb_grant_o(grant)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_slave(input int s, input bit v, input bit l, input logic [DW-1:0] d,
                             input logic [IDW-1:0] id, input logic [UW-1:0] u, input logic [1:0] r);
    bus.slv_valid_i[s]             = v;
    bus.slv_last_i[s]              = l;
    bus.slv_data_i[s*DW +: DW]     = d;
    bus.slv_id_i[s*IDW +: IDW]     = id;
    bus.slv_user_i[s*UW +: UW]     = u;
    bus.slv_resp_i[s*2 +: 2]       = r;
  endtask

  function automatic logic [63:0] mst_fields();
    return {3'b0, bus.mst_data_o, bus.mst_id_o, bus.mst_user_o, bus.mst_resp_o, bus.mst_last_o};
  endfunction

  // Table slaves carry constant per-slave fields; src 4 = all-zero, src 5 = not checked.
  function automatic logic [63:0] tbl_fields(input int src);
    if (src == 4) return 64'd0;
    return {3'b0, DW'(32'h100 + src), IDW'(16'hA0 + src), UW'(3 + src), 2'(src), 1'b0};
  endfunction

  typedef struct {
    bit       rst;
    bit [3:0] vld;
    bit [3:0] lst;
    bit       mrdy;
    bit [3:0] e_rdy;
    bit       e_mv;
    int       e_src;
    bit       e_lock;
    int       e_grant;
  } vec_t;

  vec_t tbl[14];

  typedef struct {
    int s;
    int b;
    int k;
    bit last;
  } beat_t;

  int nb[N];
  int lens[N][4];

  function automatic logic [63:0] beat_fields(input int s, input int b, input int k, input bit last);
    return {3'b0, 8'(s), 8'(b), 16'(k), IDW'(s*256 + b + 16), UW'(s*16 + k), 2'(k + s), last};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int s = 0; s < N; s++) drive_slave(s, 1'b0, 1'b0, '0, '0, '0, '0);
    bus.mst_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_scenario(input bit rand_ready, input bit gaps, input int budget,
                              output int first_cyc, output int last_cyc);
    beat_t       exp_q[$];
    int          rem[N];
    int          cur_b[N];
    int          cur_k[N];
    bit          presented[N];
    int          ptr;
    bit          any;
    bit          hold_pending;
    logic [63:0] prev_out;
    int          cycle;
    beat_t       e;

    // Reference: whole bursts, round-robin among slaves that still have bursts queued.
    ptr = 0;
    for (int s = 0; s < N; s++) rem[s] = nb[s];
    do begin
      any = 1'b0;
      for (int k = 0; k < N && !any; k++) begin
        int s;
        s = (ptr + k) % N;
        if (rem[s] > 0) begin
          int b;
          b = nb[s] - rem[s];
          for (int j = 0; j < lens[s][b]; j++) exp_q.push_back('{s, b, j, j == lens[s][b] - 1});
          rem[s]--;
          ptr = (s + 1) % N;
          any = 1'b1;
        end
      end
    end while (any);

    do_reset();
    for (int s = 0; s < N; s++) begin
      cur_b[s] = 0;
      cur_k[s] = 0;
      presented[s] = 1'b0;
    end
    hold_pending = 1'b0;
    prev_out = '0;
    first_cyc = -1;
    last_cyc = -1;
    cycle = 0;
    // Gaps only ever delay a non-first beat, so the arbitration order stays predictable.
    while (exp_q.size() > 0 && cycle < budget) begin
      if (cycle > 0) @(negedge clk);
      for (int s = 0; s < N; s++) begin
        if (!presented[s] && cur_b[s] < nb[s])
          presented[s] = (cur_k[s] == 0) || !gaps || ($urandom_range(0, 3) != 0);
        if (presented[s])
          drive_slave(s, 1'b1, cur_k[s] == lens[s][cur_b[s]] - 1, DW'(beat_fields(s, cur_b[s], cur_k[s], 1'b0) >> 29),
                      IDW'(s*256 + cur_b[s] + 16), UW'(s*16 + cur_k[s]), 2'(cur_k[s] + s));
        else
          drive_slave(s, 1'b0, 1'b0, '0, '0, '0, '0);
      end
      bus.mst_ready_i = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      chk("ready_onehot0", 64'($onehot0(bus.slv_ready_o)), 64'd1);
      if (hold_pending) chk("stall_hold", mst_fields(), prev_out);
      if (bus.mst_valid_o && !bus.mst_ready_i) chk("stall_ready_zero", 64'(bus.slv_ready_o), 64'd0);
      if (bus.mst_valid_o && bus.mst_ready_i) begin
        e = exp_q.pop_front();
        chk("beat", mst_fields(), beat_fields(e.s, e.b, e.k, e.last));
        chk("beat_grant_lock", {61'd0, locked, grant}, {61'd0, !e.last, IW'(e.s)});
        if (first_cyc < 0) first_cyc = cycle;
        last_cyc = cycle;
      end
      for (int s = 0; s < N; s++) begin
        if (presented[s] && bus.slv_ready_o[s]) begin
          presented[s] = 1'b0;
          if (cur_k[s] == lens[s][cur_b[s]] - 1) begin
            cur_k[s] = 0;
            cur_b[s]++;
          end else begin
            cur_k[s]++;
          end
        end
      end
      hold_pending = bus.mst_valid_o && !bus.mst_ready_i;
      prev_out = mst_fields();
      cycle++;
    end
    if (exp_q.size() != 0) chk("beats_outstanding_at_budget", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int f, l;
    bus.slv_valid_i = '0;
    bus.slv_last_i  = '0;
    bus.slv_data_i  = '0;
    bus.slv_id_i    = '0;
    bus.slv_user_i  = '0;
    bus.slv_resp_i  = '0;
    bus.mst_ready_i = 1'b1;
    repeat (2) @(posedge clk);

    tbl[0]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 4, 1'b0, 0};
    tbl[1]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2, 1'b1, 2};
    tbl[2]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2, 1'b1, 2};
    tbl[3]  = '{1'b1, 4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 2, 1'b0, 2};
    tbl[4]  = '{1'b1, 4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b1, 0, 1'b0, 0};
    tbl[5]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2, 1'b0, 2};
    tbl[6]  = '{1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 2, 1'b0, 2};
    tbl[7]  = '{1'b1, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 3, 1'b0, 3};
    tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 5, 1'b0, 3};
    tbl[9]  = '{1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 1, 1'b1, 1};
    tbl[10] = '{1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 4, 1'b0, 0};
    tbl[11] = '{1'b1, 4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b1, 1, 1'b0, 1};
    tbl[12] = '{1'b1, 4'b1010, 4'b1010, 1'b1, 4'b1000, 1'b1, 3, 1'b0, 3};
    tbl[13] = '{1'b1, 4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b1, 1, 1'b0, 1};

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst;
      for (int s = 0; s < N; s++)
        drive_slave(s, tbl[i].vld[s], tbl[i].lst[s], DW'(32'h100 + s), IDW'(16'hA0 + s), UW'(3 + s), 2'(s));
      bus.mst_ready_i = tbl[i].mrdy;
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(bus.slv_ready_o), 64'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_state", i), {60'd0, bus.mst_valid_o, locked, grant},
          {60'd0, tbl[i].e_mv, tbl[i].e_lock, IW'(tbl[i].e_grant)});
      if (tbl[i].e_src != 5)
        chk($sformatf("tbl%0d_fields", i), mst_fields() & ~64'd1, tbl_fields(tbl[i].e_src));
    end

    // Every slave holds one 2-beat burst: order 0,1,2,3 in 8 back-to-back cycles.
    for (int s = 0; s < N; s++) begin
      nb[s] = 1;
      lens[s][0] = 2;
    end
    run_scenario(1'b0, 1'b0, 100, f, l);
    chk("stream_span_cycles", 64'(l - f), 64'd7);

    // Single-beat bursts from slaves 1 and 2 only: grant alternates 1,2,1,2.
    for (int s = 0; s < N; s++) nb[s] = 0;
    nb[1] = 2; nb[2] = 2;
    for (int b = 0; b < 4; b++) begin
      lens[1][b] = 1;
      lens[2][b] = 1;
    end
    run_scenario(1'b0, 1'b0, 100, f, l);

    for (int it = 0; it < 25; it++) begin
      for (int s = 0; s < N; s++) begin
        nb[s] = $urandom_range(0, 3);
        for (int b = 0; b < 4; b++) lens[s][b] = $urandom_range(1, 5);
      end
      run_scenario(1'b1, 1'b1, 600, f, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
